alu_op_ctrl: RTL and testbench

ALU_OP_CTRL -- requirements
Module: alu_op_ctrl

---
 rtl/alu_op_ctrl.sv | 130 +++++++++++++
 tb/tb_alu_op_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_ctrl
// Brief    : Drives result-mux select lines for an ALU opcode, waits one or
//            MULTI_LAT cycles, captures the selected result and presents it on
//            a valid/ready response port.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_ctrl #(
    parameter int WIDTH     = 32,
    parameter int MULTI_LAT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_opcode,
    output logic             ctrl_s0,
    output logic             ctrl_s1,
    output logic             ctrl_s2,
    input  logic [WIDTH-1:0] mux_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       rsp_opcode,
    output logic             busy
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_wait   = 2'd2;
    localparam logic [1:0] c_st_hold   = 2'd3;

    localparam logic [3:0] c_lat_init  = 4'(MULTI_LAT - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [2:0]       r_sel;
    logic [3:0]       r_cnt;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [2:0]       r_rsp_opcode;
    logic             w_accept;
    logic             w_multi;
    logic             w_capture;

    assign w_accept  = req_valid && req_ready;
    assign w_multi   = req_opcode[2] && req_opcode[1];
    // Single-cycle ops capture straight out of SETTLE; multi-cycle ops once the
    // down-counter has run out.
    assign w_capture = (r_state == c_st_settle) ||
                       ((r_state == c_st_wait) && (r_cnt == 4'd0));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_next_state = w_multi ? c_st_wait : c_st_settle;
                end
            end
            c_st_settle: begin
                w_next_state = c_st_hold;
            end
            c_st_wait: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = c_st_hold;
                end
            end
            c_st_hold: begin
                if (w_accept) begin
                    w_next_state = w_multi ? c_st_wait : c_st_settle;
                end else if (rsp_ready) begin
                    w_next_state = c_st_idle;
                end
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    always_comb begin
        req_ready = (r_state == c_st_idle) || ((r_state == c_st_hold) && rsp_ready);
        busy      = (r_state != c_st_idle);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sel        <= 3'd0;
            r_cnt        <= 4'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_opcode <= 3'd0;
        end else begin
            if (w_accept) begin
                r_sel <= req_opcode;
                r_cnt <= w_multi ? c_lat_init : 4'd0;
            end else if ((r_state == c_st_wait) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // Retirement in HOLD and a capture are mutually exclusive by state.
            if (w_capture) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_data   <= mux_out;
                r_rsp_opcode <= r_sel;
            end else if ((r_state == c_st_hold) && rsp_ready) begin
                r_rsp_valid  <= 1'b0;
            end
        end
    end

    assign ctrl_s0    = r_sel[0];
    assign ctrl_s1    = r_sel[1];
    assign ctrl_s2    = r_sel[2];
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_opcode = r_rsp_opcode;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_ctrl
// Brief    : Self-checking bench for alu_op_ctrl: directed scenarios plus a
//            randomized run against a transaction-level latency model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_ctrl;

    localparam int W  = 32;
    localparam int ML = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_opcode;
    logic         ctrl_s0, ctrl_s1, ctrl_s2;
    logic [W-1:0] mux_out;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic [2:0]   rsp_opcode;
    logic         busy;
    logic [2:0]   sel;

    int vectors = 0;
    int errors  = 0;

    assign sel = {ctrl_s2, ctrl_s1, ctrl_s0};

    alu_op_ctrl #(.WIDTH(W), .MULTI_LAT(ML)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .ctrl_s0    (ctrl_s0),
        .ctrl_s1    (ctrl_s1),
        .ctrl_s2    (ctrl_s2),
        .mux_out    (mux_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_opcode (rsp_opcode),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_opcode = 3'd0; mux_out = '0; rsp_ready = 1'b0;
        #12;
        vectors++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %b want 000", sel); end
        vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        vectors++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", rsp_data); end
        vectors++; if (rsp_opcode !== 3'd0) begin errors++; $display("FAIL reset_opcode: got %0d want 0", rsp_opcode); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_basic;
        req_valid = 1'b1; req_opcode = 3'd3; mux_out = 32'h0000_00A5; rsp_ready = 1'b1;
        tick;
        req_valid = 1'b0;
        vectors++; if (sel !== 3'b011) begin errors++; $display("FAIL basic_sel: got %b want 011", sel); end
        vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", rsp_valid); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        tick;
        vectors++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", rsp_valid); end
        vectors++; if (rsp_data !== 32'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", rsp_data); end
        vectors++; if (rsp_opcode !== 3'd3) begin errors++; $display("FAIL basic_opcode: got %0d want 3", rsp_opcode); end
        tick;
        vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_retire: got %b want 0", rsp_valid); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b want 0", busy); end
    endtask

    task automatic test_multicycle;
        req_valid = 1'b1; req_opcode = 3'd7; rsp_ready = 1'b1;
        tick;
        req_valid = 1'b0;
        for (int k = 1; k <= ML; k++) begin
            mux_out = W'(k);
            #1;
            vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL multi_early_valid: cycle %0d got %b want 0", k, rsp_valid); end
            vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL multi_ready: cycle %0d got %b want 0", k, req_ready); end
            tick;
        end
        vectors++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL multi_valid: got %b want 1", rsp_valid); end
        vectors++; if (rsp_data !== W'(ML)) begin errors++; $display("FAIL multi_data: got %0d want %0d", rsp_data, ML); end
        vectors++; if (rsp_opcode !== 3'd7) begin errors++; $display("FAIL multi_opcode: got %0d want 7", rsp_opcode); end
        tick;
    endtask

    task automatic test_stall;
        logic [W-1:0] d;
        d = $urandom;
        req_valid = 1'b1; req_opcode = 3'd2; mux_out = d; rsp_ready = 1'b0;
        tick;
        req_valid = 1'b0;
        tick;
        for (int k = 0; k < 5; k++) begin
            mux_out = $urandom; req_valid = 1'b1; req_opcode = 3'd5;
            tick;
            vectors++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: cycle %0d got %b want 1", k, rsp_valid); end
            vectors++; if (rsp_data !== d) begin errors++; $display("FAIL stall_data: cycle %0d got %h want %h", k, rsp_data, d); end
            vectors++; if (sel !== 3'd2) begin errors++; $display("FAIL stall_sel: cycle %0d got %b want 010", k, sel); end
            vectors++; if (rsp_opcode !== 3'd2) begin errors++; $display("FAIL stall_opcode: cycle %0d got %0d want 2", k, rsp_opcode); end
            vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: cycle %0d got %b want 0", k, req_ready); end
        end
        rsp_ready = 1'b1;
        #1;
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", req_ready); end
        tick;
        req_valid = 1'b0;
        vectors++; if (sel !== 3'd5) begin errors++; $display("FAIL stall_new_sel: got %b want 101", sel); end
        vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_retire: got %b want 0", rsp_valid); end
        d = $urandom; mux_out = d;
        tick;
        vectors++; if (rsp_data !== d || rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_new_rsp: got %h/%b want %h/1", rsp_data, rsp_valid, d); end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] d;
        d = $urandom;
        req_valid = 1'b1; req_opcode = 3'd1; mux_out = d; rsp_ready = 1'b1;
        tick;
        req_opcode = 3'd6;
        tick;
        vectors++; if (rsp_valid !== 1'b1 || rsp_data !== d) begin errors++; $display("FAIL b2b_first_rsp: got %b/%h want 1/%h", rsp_valid, rsp_data, d); end
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
        tick;
        req_valid = 1'b0;
        vectors++; if (sel !== 3'b110) begin errors++; $display("FAIL b2b_sel: got %b want 110", sel); end
        vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_retire: got %b want 0", rsp_valid); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_idle: got %b want 1", busy); end
        d = $urandom; mux_out = d;
        for (int k = 0; k < ML; k++) tick;
        vectors++; if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_opcode !== 3'd6) begin
            errors++; $display("FAIL b2b_second_rsp: got %b/%h/%0d want 1/%h/6", rsp_valid, rsp_data, rsp_opcode, d);
        end
        tick;
    endtask

    task automatic test_reset_mid_wait;
        logic [W-1:0] d;
        req_valid = 1'b1; req_opcode = 3'd6; mux_out = $urandom; rsp_ready = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        #1;
        vectors++; if (sel !== 3'd0) begin errors++; $display("FAIL midrst_sel: got %b want 000", sel); end
        vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", rsp_valid); end
        vectors++; if (rsp_data !== '0) begin errors++; $display("FAIL midrst_data: got %h want 0", rsp_data); end
        vectors++; if (rsp_opcode !== 3'd0) begin errors++; $display("FAIL midrst_opcode: got %0d want 0", rsp_opcode); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k < ML + 2; k++) begin
            tick;
            vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL midrst_ghost: cycle %0d got valid %b busy %b want 0 0", k, rsp_valid, busy);
            end
        end
        d = $urandom;
        req_valid = 1'b1; req_opcode = 3'd0; mux_out = d;
        tick;
        req_valid = 1'b0;
        tick;
        vectors++; if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_opcode !== 3'd0) begin
            errors++; $display("FAIL midrst_recover: got %b/%h/%0d want 1/%h/0", rsp_valid, rsp_data, rsp_opcode, d);
        end
        tick;
    endtask

    task automatic test_sweep;
        logic [W-1:0] d;
        int lat;
        int exp_lat;
        for (int op = 0; op < 8; op++) begin
            d = $urandom;
            exp_lat = (op >= 6) ? ML : 1;
            req_valid = 1'b1; req_opcode = 3'(op); mux_out = d; rsp_ready = 1'b1;
            tick;
            req_valid = 1'b0;
            vectors++; if (sel !== 3'(op)) begin errors++; $display("FAIL sweep_sel: op %0d got %b", op, sel); end
            lat = 0;
            while (rsp_valid !== 1'b1 && lat < 20) begin
                tick;
                lat++;
            end
            vectors++; if (lat != exp_lat) begin errors++; $display("FAIL sweep_latency: op %0d got %0d want %0d", op, lat, exp_lat); end
            vectors++; if (rsp_data !== d || rsp_opcode !== 3'(op)) begin
                errors++; $display("FAIL sweep_rsp: op %0d got %h/%0d want %h/%0d", op, rsp_data, rsp_opcode, d, op);
            end
            tick;
        end
    endtask

    // Reference: each accepted op completes a fixed number of edges later
    // (1 or MULTI_LAT); the result then sits until the consumer takes it.
    task automatic test_random;
        bit           m_pend, m_hold, m_ready, acc;
        int           m_left;
        logic [2:0]   m_pop, m_op, m_sel;
        logic [W-1:0] m_data;
        logic         rv, rr;
        logic [2:0]   op;
        logic [W-1:0] mo;
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        #2;
        reset = 1'b0;
        tick;
        m_pend = 0; m_hold = 0; m_left = 0; m_pop = 0; m_op = 0; m_sel = 0; m_data = '0;
        for (int c = 0; c < 300; c++) begin
            rv = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            mo = $urandom;
            req_valid = rv; rsp_ready = rr; req_opcode = op; mux_out = mo;
            #1;
            m_ready = !m_pend && (!m_hold || rr);
            vectors++; if (req_ready !== m_ready) begin errors++; $display("FAIL rand_ready: cycle %0d got %b want %b", c, req_ready, m_ready); end
            acc = rv && m_ready;
            @(posedge clock);
            if (m_hold && rr) m_hold = 0;
            if (m_pend) begin
                m_left--;
                if (m_left == 0) begin
                    m_hold = 1; m_data = mo; m_op = m_pop; m_pend = 0;
                end
            end
            if (acc) begin
                m_pend = 1; m_pop = op; m_sel = op; m_left = (op >= 3'd6) ? ML : 1;
            end
            #1;
            vectors++; if (rsp_valid !== m_hold) begin errors++; $display("FAIL rand_valid: cycle %0d got %b want %b", c, rsp_valid, m_hold); end
            vectors++; if (rsp_data !== m_data) begin errors++; $display("FAIL rand_data: cycle %0d got %h want %h", c, rsp_data, m_data); end
            vectors++; if (rsp_opcode !== m_op) begin errors++; $display("FAIL rand_opcode: cycle %0d got %0d want %0d", c, rsp_opcode, m_op); end
            vectors++; if (sel !== m_sel) begin errors++; $display("FAIL rand_sel: cycle %0d got %b want %b", c, sel, m_sel); end
            vectors++; if (busy !== (m_pend || m_hold)) begin errors++; $display("FAIL rand_busy: cycle %0d got %b want %b", c, busy, m_pend || m_hold); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_multicycle;
        test_stall;
        test_back_to_back;
        test_reset_mid_wait;
        test_sweep;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
